fb_write_arbiter: RTL

- Owns the frameRAM write port: drives WE, write_address and write data.
- Shares the port between the blue and red trail writers, with round-robin arbitration.
- Runs a full-screen clear sweep on command, for game start or restart.
- Converts pixel coordinates into the frame-buffer word format: 2 pixels per 16-bit word, nibbles [3:0] and [11:8], address = X/2 + Y*320.

---
 rtl/fb_write_arbiter_pkg.sv | 24 ++
 rtl/fb_write_arbiter_if.sv | 32 +++
 rtl/fb_write_arbiter_clear_seq.sv | 37 +++
 rtl/fb_write_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared frame-buffer constants, state/requester types and the pixel-to-word helpers.
package fb_pkg;

  localparam int unsigned H_RES          = 640;
  localparam int unsigned V_RES          = 480;
  localparam int unsigned WORDS_PER_LINE = 320;
  localparam int unsigned FB_WORDS       = 153600;
  localparam int unsigned PIX_ADDR_W     = 19;

  typedef enum logic [1:0] {IDLE, SERVE, CLEAR} fb_state_t;
  typedef enum logic {BLUE = 1'b0, RED = 1'b1} req_id_t;

  // Trails are 2 px wide, so both pixels of a word take the same colour.
  function automatic logic [15:0] pack_word(input logic [3:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

  function automatic logic [PIX_ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [PIX_ADDR_W-1:0] yy;
    yy = PIX_ADDR_W'(y);
    return (yy << 8) + (yy << 6) + PIX_ADDR_W'(x >> 1);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// frameRAM write-port bundle: clear command, blue/red trail requests and the RAM write signals.
interface fb_write_arbiter_if #(parameter int unsigned ADDR_W = 19);

  logic              clear_start;
  logic              clear_busy;
  logic              blue_req;
  logic [9:0]        blue_x;
  logic [9:0]        blue_y;
  logic [3:0]        blue_color;
  logic              blue_ack;
  logic              red_req;
  logic [9:0]        red_x;
  logic [9:0]        red_y;
  logic [3:0]        red_color;
  logic              red_ack;
  logic              WE;
  logic [ADDR_W-1:0] write_address;
  logic [15:0]       Data_In;

  modport master (
    output clear_start, blue_req, blue_x, blue_y, blue_color,
           red_req, red_x, red_y, red_color,
    input  clear_busy, blue_ack, red_ack, WE, write_address, Data_In
  );

  modport slave (
    input  clear_start, blue_req, blue_x, blue_y, blue_color,
           red_req, red_x, red_y, red_color,
    output clear_busy, blue_ack, red_ack, WE, write_address, Data_In
  );

endinterface

// File: rtl/fb_write_arbiter_clear_seq.sv
// Clear-sweep address generator. o_addr is the address to issue this cycle (0 on the start cycle);
// o_done flags the final address of the sweep.
module fb_clear_seq #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned N_WORDS = 153600
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

  logic              r_busy;
  logic [ADDR_W-1:0] r_cnt;

  assign o_addr = i_start ? '0 : r_cnt;
  assign o_busy = i_start | r_busy;
  assign o_done = o_busy && (o_addr == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (o_done) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (o_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= o_addr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// frameRAM write-port owner: round-robin blue/red trail writes plus a full-screen clear sweep.
// Define FB_AUTO_CLEAR_EN to start a clear sweep automatically on the first edge after reset.
module fb_write_arbiter #(
  parameter int unsigned H_RES       = fb_pkg::H_RES,
  parameter int unsigned V_RES       = fb_pkg::V_RES,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [3:0]  CLEAR_COLOR = 4'h8
) (
  input  logic               Clk,
  input  logic               Reset,
  fb_write_arbiter_if.slave  bus
);

  import fb_pkg::*;

  localparam int unsigned N_WORDS = (H_RES / 2) * V_RES;
  localparam logic [10:0] H_LIM   = 11'(H_RES);
  localparam logic [10:0] V_LIM   = 11'(V_RES);

  fb_state_t         r_state;
  req_id_t           r_rr_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_blue_ack;
  logic              r_red_ack;
  logic              r_busy;

  logic              w_clear_req;
  logic              w_clear_go;
  logic              w_blue_elig;
  logic              w_red_elig;
  logic              w_grant;
  logic              w_pick_red;
  logic [9:0]        w_gx;
  logic [9:0]        w_gy;
  logic [3:0]        w_gc;
  logic              w_in_range;
  logic              w_seq_busy;
  logic [ADDR_W-1:0] w_seq_addr;
  logic              w_seq_done;

`ifdef FB_AUTO_CLEAR_EN
  logic r_auto;
  assign w_clear_req = bus.clear_start | r_auto;
`else
  assign w_clear_req = bus.clear_start;
`endif

  assign w_clear_go  = (r_state != CLEAR) && w_clear_req;

  // A requester acked this cycle is still holding its old pixel; keep it out of the race.
  assign w_blue_elig = bus.blue_req && !r_blue_ack;
  assign w_red_elig  = bus.red_req  && !r_red_ack;
  assign w_grant     = w_blue_elig || w_red_elig;
  assign w_pick_red  = w_red_elig && (!w_blue_elig || (r_rr_last == BLUE));

  assign w_gx        = w_pick_red ? bus.red_x     : bus.blue_x;
  assign w_gy        = w_pick_red ? bus.red_y     : bus.blue_y;
  assign w_gc        = w_pick_red ? bus.red_color : bus.blue_color;
  assign w_in_range  = ({1'b0, w_gx} < H_LIM) && ({1'b0, w_gy} < V_LIM);

  fb_clear_seq #(
    .ADDR_W  (ADDR_W),
    .N_WORDS (N_WORDS)
  ) u_clear_seq (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_start (w_clear_go),
    .o_busy  (w_seq_busy),
    .o_addr  (w_seq_addr),
    .o_done  (w_seq_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_rr_last  <= RED;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_blue_ack <= 1'b0;
      r_red_ack  <= 1'b0;
      r_busy     <= 1'b0;
`ifdef FB_AUTO_CLEAR_EN
      r_auto     <= 1'b1;
`endif
    end else begin
`ifdef FB_AUTO_CLEAR_EN
      r_auto     <= 1'b0;
`endif
      r_we       <= 1'b0;
      r_blue_ack <= 1'b0;
      r_red_ack  <= 1'b0;
      r_busy     <= 1'b0;
      if (r_state == CLEAR || w_clear_go) begin
        // Sweep write; clear_start during the sweep and pending requests are simply not looked at.
        r_we   <= w_seq_busy;
        r_busy <= w_seq_busy;
        r_addr <= w_seq_addr;
        r_data <= pack_word(CLEAR_COLOR);
        r_state <= w_seq_done ? IDLE : CLEAR;
      end else if (w_grant) begin
        r_blue_ack <= !w_pick_red;
        r_red_ack  <= w_pick_red;
        r_rr_last  <= w_pick_red ? RED : BLUE;
        if (w_in_range) begin
          r_we    <= 1'b1;
          r_addr  <= ADDR_W'(pix_addr(w_gx, w_gy));
          r_data  <= pack_word(w_gc);
          r_state <= SERVE;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.WE            = r_we;
  assign bus.write_address = r_addr;
  assign bus.Data_In       = r_data;
  assign bus.blue_ack      = r_blue_ack;
  assign bus.red_ack       = r_red_ack;
  assign bus.clear_busy    = r_busy;

endmodule
